// File: rtl/ntt_unified_ctrl.sv
// ============================================================================
// Module   : ntt_unified_ctrl
// Brief    : Forward/inverse NTT address and control sequencer, one butterfly
//            per cycle, with a write-back address delay pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ntt_unified_ctrl #(
    parameter int LOGN     = 8,
    parameter int PIPE_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] zeta_idx,
    output logic            zeta_neg,
    output logic [1:0]      op,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [LOGN:0]   c_n         = {1'b1, {LOGN{1'b0}}};
    localparam logic [LOGN:0]   c_half      = {2'b01, {(LOGN-1){1'b0}}};
    localparam logic [DW-1:0]   c_dcnt_init = DW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEVEL, S_ISSUE, S_DRAIN,
        S_SCALE_SETUP, S_SCALE_ISSUE, S_SCALE_DRAIN, S_DONE
    } state_t;

    state_t          state_q;
    logic            mode_q;
    logic [LOGN:0]   len_q, j_q, sp_q, j_d, sp_d;
    logic [LOGN-1:0] k_q, k_d;
    logic [DW-1:0]   dcnt_q;
    logic            w_grp_end, w_lvl_end;
    logic [LOGN-1:0] w_b_d, w_sj_d, w_sb_d;

    // Next butterfly pair within the current level, and the next scale pair
    always_comb begin
        w_grp_end = (j_q == sp_q + len_q - (LOGN+1)'(1));
        sp_d      = sp_q;
        k_d       = k_q;
        j_d       = j_q + (LOGN+1)'(1);
        if (w_grp_end) begin
            sp_d = sp_q + (len_q << 1);
            j_d  = sp_d;
            k_d  = mode_q ? (k_q - LOGN'(1)) : (k_q + LOGN'(1));
        end
        w_lvl_end = w_grp_end && (sp_d == c_n);
        w_b_d     = j_d[LOGN-1:0] + len_q[LOGN-1:0];
        w_sj_d    = j_q[LOGN-1:0] + LOGN'(1);
        w_sb_d    = w_sj_d + c_half[LOGN-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            len_q     <= '0;
            k_q       <= '0;
            j_q       <= '0;
            sp_q      <= '0;
            dcnt_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            zeta_idx  <= '0;
            zeta_neg  <= 1'b0;
            op        <= 2'd0;
        end else begin
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            zeta_idx  <= '0;
            zeta_neg  <= 1'b0;
            op        <= 2'd0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LEVEL;
                        busy    <= 1'b1;
                        mode_q  <= mode;
                        len_q   <= mode ? (LOGN+1)'(1) : c_half;
                        k_q     <= mode ? '1 : LOGN'(1);
                    end
                end
                S_LEVEL: begin
                    j_q       <= '0;
                    sp_q      <= '0;
                    state_q   <= S_ISSUE;
                    rd_en     <= 1'b1;
                    rd_addr_b <= len_q[LOGN-1:0];
                    zeta_idx  <= k_q;
                    zeta_neg  <= mode_q;
                    op        <= {1'b0, mode_q};
                end
                S_ISSUE: begin
                    j_q  <= j_d;
                    sp_q <= sp_d;
                    k_q  <= k_d;
                    if (w_lvl_end) begin
                        state_q <= S_DRAIN;
                        dcnt_q  <= c_dcnt_init;
                    end else begin
                        rd_en     <= 1'b1;
                        rd_addr_a <= j_d[LOGN-1:0];
                        rd_addr_b <= w_b_d;
                        zeta_idx  <= k_d;
                        zeta_neg  <= mode_q;
                        op        <= {1'b0, mode_q};
                    end
                end
                S_DRAIN: begin
                    if (dcnt_q != '0) begin
                        dcnt_q <= dcnt_q - DW'(1);
                    end else if (mode_q ? (len_q == c_half) : (len_q == (LOGN+1)'(1))) begin
                        state_q <= mode_q ? S_SCALE_SETUP : S_DONE;
                        done    <= ~mode_q;
                    end else begin
                        len_q   <= mode_q ? (len_q << 1) : (len_q >> 1);
                        state_q <= S_LEVEL;
                    end
                end
                S_SCALE_SETUP: begin
                    j_q       <= '0;
                    state_q   <= S_SCALE_ISSUE;
                    rd_en     <= 1'b1;
                    rd_addr_b <= c_half[LOGN-1:0];
                    op        <= 2'd2;
                end
                S_SCALE_ISSUE: begin
                    if (j_q == c_half - (LOGN+1)'(1)) begin
                        state_q <= S_SCALE_DRAIN;
                        dcnt_q  <= c_dcnt_init;
                    end else begin
                        j_q       <= j_q + (LOGN+1)'(1);
                        rd_en     <= 1'b1;
                        rd_addr_a <= w_sj_d;
                        rd_addr_b <= w_sb_d;
                        op        <= 2'd2;
                    end
                end
                S_SCALE_DRAIN: begin
                    if (dcnt_q != '0) begin
                        dcnt_q <= dcnt_q - DW'(1);
                    end else begin
                        state_q <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Write-back pipeline: stage 0 holds the read issued one cycle earlier
    logic [PIPE_LAT-1:0] vld_q;
    logic [LOGN-1:0]     pa_q [PIPE_LAT];
    logic [LOGN-1:0]     pb_q [PIPE_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            pa_q[0]  <= rd_addr_a;
            pb_q[0]  <= rd_addr_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                pa_q[i]  <= pa_q[i-1];
                pb_q[i]  <= pb_q[i-1];
            end
        end
    end

    assign wr_en     = vld_q[PIPE_LAT-1];
    assign wr_addr_a = pa_q[PIPE_LAT-1];
    assign wr_addr_b = pb_q[PIPE_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_ntt_unified_ctrl.sv
// ============================================================================
// Module   : tb_ntt_unified_ctrl
// Brief    : Randomized cycle-accurate check of ntt_unified_ctrl against a
//            loop-nest model of the NTT level/group/pair schedule.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ntt_unified_ctrl;

    localparam int LOGN = 3;
    localparam int PL   = 2;
    localparam int N    = 1 << LOGN;
    localparam int H    = N / 2;
    localparam int MAXC = 64;

    logic            clk, rst, start, mode;
    logic            busy, done, rd_en, zeta_neg, wr_en;
    logic [LOGN-1:0] rd_addr_a, rd_addr_b, zeta_idx, wr_addr_a, wr_addr_b;
    logic [1:0]      op;

    ntt_unified_ctrl #(.LOGN(LOGN), .PIPE_LAT(PL)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .zeta_idx(zeta_idx), .zeta_neg(zeta_neg), .op(op),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(
        input logic b, input logic d, input logic r,
        input logic [LOGN-1:0] a, input logic [LOGN-1:0] bb, input logic [LOGN-1:0] z,
        input logic ng, input logic [1:0] o,
        input logic w, input logic [LOGN-1:0] wa, input logic [LOGN-1:0] wb);
        return 64'({b, d, r, a, bb, z, ng, o, w, wa, wb});
    endfunction

    logic [63:0] obs;
    assign obs = pack(busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, zeta_neg, op,
                      wr_en, wr_addr_a, wr_addr_b);

    logic            e_rd [MAXC], e_neg [MAXC], e_busy [MAXC], e_done [MAXC];
    logic [LOGN-1:0] e_a [MAXC], e_b [MAXC], e_z [MAXC];
    logic [1:0]      e_op [MAXC];
    logic [63:0]     exp_v [MAXC];
    int              done_cyc;

    // Each level takes one setup cycle, H issue cycles and PL drain cycles
    task automatic build(input bit m);
        int len, k, base, c;
        for (int i = 0; i < MAXC; i++) begin
            e_rd[i] = 0; e_neg[i] = 0; e_busy[i] = 0; e_done[i] = 0;
            e_a[i] = '0; e_b[i] = '0; e_z[i] = '0; e_op[i] = '0;
        end
        len  = m ? 1 : H;
        k    = m ? N - 1 : 1;
        base = 1;
        for (int lv = 0; lv < LOGN; lv++) begin
            c = base + 1;
            for (int s = 0; s < N; s += 2 * len) begin
                for (int j = s; j < s + len; j++) begin
                    e_rd[c] = 1; e_a[c] = LOGN'(j); e_b[c] = LOGN'(j + len);
                    e_z[c] = LOGN'(k); e_op[c] = m ? 2'd1 : 2'd0; e_neg[c] = m;
                    c++;
                end
                k = m ? k - 1 : k + 1;
            end
            base += H + PL + 1;
            len = m ? len * 2 : len / 2;
        end
        if (m) begin
            c = base + 1;
            for (int j = 0; j < H; j++) begin
                e_rd[c] = 1; e_a[c] = LOGN'(j); e_b[c] = LOGN'(j + H); e_op[c] = 2'd2;
                c++;
            end
            base += H + PL + 1;
        end
        done_cyc = base;
        e_done[base] = 1;
        for (int i = 1; i <= base; i++) e_busy[i] = 1;
        for (int i = 0; i < MAXC; i++) begin
            if (i >= PL)
                exp_v[i] = pack(e_busy[i], e_done[i], e_rd[i], e_a[i], e_b[i], e_z[i], e_neg[i],
                                e_op[i], e_rd[i-PL], e_a[i-PL], e_b[i-PL]);
            else
                exp_v[i] = pack(e_busy[i], e_done[i], e_rd[i], e_a[i], e_b[i], e_z[i], e_neg[i],
                                e_op[i], 1'b0, '0, '0);
        end
    endtask

    task automatic run(input bit m, input int abort_c);
        int  ndone, last_wr;
        bit  prev_rd;
        ndone = 0; last_wr = -1; prev_rd = 0;
        build(m);
        for (int c = 0; c <= done_cyc + 3; c++) begin
            @(negedge clk);
            if (c == abort_c) begin
                rst   = 1'b1;
                start = 1'b0;
                #1;
                check("abort_zero", obs, 64'd0);
                repeat (2) begin
                    @(negedge clk);
                    check("rst_hold", obs, 64'd0);
                end
                rst = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("post_rst", obs, 64'd0);
                end
                check("abort_nodone", 64'(ndone), 64'd0);
                return;
            end
            check($sformatf("m%0d_c%0d", m, c), obs, exp_v[c]);
            if (done) ndone++;
            if (rd_en && !prev_rd && last_wr >= 0)
                check($sformatf("hazard_c%0d", c), 64'(c > last_wr), 64'd1);
            if (wr_en) last_wr = c;
            prev_rd = rd_en;
            if (c == 0) begin
                start = 1'b1;
                mode  = m;
            end else if (c <= done_cyc && (c == 3 || c == done_cyc || $urandom_range(0, 5) == 0)) begin
                start = 1'b1;
                mode  = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        check("done_count", 64'(ndone), 64'd1);
    endtask

    initial begin
        bit m;
        int ab;
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", obs, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle", obs, 64'd0);
        run(1'b0, -1);
        run(1'b1, -1);
        run(1'b1, 18);
        run(1'b1, -1);
        run(1'b0, 17);
        run(1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            m  = 1'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(16, 20)) : -1;
            run(m, ab);
            if (ab >= 0) run(m, -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
